// File: rtl/seq_divider.sv
// Sequential restoring divider with signed/unsigned operation.
//
// Ports:
//   clock, reset    - sole clock; synchronous active-high reset
//   flush           - synchronous abort of any operation in flight
//   in_valid        - operands present; accepted only in idle without flush
//   in_hold         - high while busy; upstream keeps operands stable
//   in_signed       - 1 = two's-complement divide, 0 = unsigned
//   numer, denom    - dividend and divisor
//   out_valid       - result registers hold a completed result
//   out_hold        - downstream stall; holds the result in done
//   quotient        - registered quotient
//   remainder       - registered remainder (sign follows the dividend)
//   flags           - registered {carry, negative, overflow, zero}
module seq_divider #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_hold,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] numer,
  input  logic [WIDTH-1:0] denom,
  output logic             out_valid,
  input  logic             out_hold,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [3:0]       flags
);

  localparam int unsigned N    = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WB   = WIDTH + BITS_PER_CYCLE;

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StIterate, StFixup, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  work_q, work_d;   // dividend bits shifted out, quotient bits shifted in
  logic [WIDTH-1:0]  rem_q, rem_d;     // partial remainder magnitude
  logic [WIDTH-1:0]  den_q, den_d;     // divisor magnitude
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              neg_q_q, neg_q_d; // quotient must be negated
  logic              neg_r_q, neg_r_d; // remainder must be negated
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rmd_q, rmd_d;
  logic [3:0]        flags_q, flags_d;

  logic              accept;
  logic              num_neg, den_neg, min_ovf;
  logic [WIDTH-1:0]  num_abs, den_abs;
  logic [WB-1:0]     den_ext, step_r;
  logic [WIDTH-1:0]  step_w;
  logic [WIDTH-1:0]  fix_q, fix_r;

  assign accept  = (state_q == StIdle) && in_valid && !flush;
  assign num_neg = in_signed & numer[WIDTH-1];
  assign den_neg = in_signed & denom[WIDTH-1];
  assign num_abs = num_neg ? -numer : numer;
  assign den_abs = den_neg ? -denom : denom;
  assign min_ovf = in_signed && (numer == MinVal) && (&denom);

  assign den_ext = {{BITS_PER_CYCLE{1'b0}}, den_q};
  assign fix_q   = neg_q_q ? -work_q : work_q;
  assign fix_r   = neg_r_q ? -rem_q : rem_q;

  // One iteration: retire BITS_PER_CYCLE restoring shift-subtract steps.
  // The extra BITS_PER_CYCLE bits keep the shifted partial remainder intact.
  always_comb begin
    step_r = {{BITS_PER_CYCLE{1'b0}}, rem_q};
    step_w = work_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      step_r = {step_r[WB-2:0], step_w[WIDTH-1]};
      step_w = {step_w[WIDTH-2:0], 1'b0};
      if (step_r >= den_ext) begin
        step_r    = step_r - den_ext;
        step_w[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    flags_d = flags_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (denom == '0) begin
            quo_d   = '1;
            rmd_d   = numer;
            flags_d = 4'b0110;
            state_d = StDone;
          end else if (min_ovf) begin
            quo_d   = MinVal;
            rmd_d   = '0;
            flags_d = 4'b0110;
            state_d = StDone;
          end else begin
            work_d  = num_abs;
            rem_d   = '0;
            den_d   = den_abs;
            cnt_d   = '0;
            neg_q_d = num_neg ^ den_neg;
            neg_r_d = num_neg;
            state_d = StIterate;
          end
        end
      end
      StIterate: begin
        work_d = step_w;
        rem_d  = step_r[WIDTH-1:0];
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(N - 1)) state_d = StFixup;
      end
      StFixup: begin
        quo_d   = fix_q;
        rmd_d   = fix_r;
        flags_d = {1'b0, fix_q[WIDTH-1], 1'b0, (fix_q == '0)};
        state_d = StDone;
      end
      StDone: begin
        if (!out_hold) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort: drop the operation and leave the previous result untouched.
    if (flush) begin
      state_d = StIdle;
      quo_d   = quo_q;
      rmd_d   = rmd_q;
      flags_d = flags_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      cnt_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      flags_q <= flags_d;
    end
  end

  assign in_hold   = (state_q != StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign flags     = flags_q;

endmodule
